fp_io_sequencer: RTL and testbench

Transaction controller for the half-precision adder's serial I/O path. Steers an incoming bit stream into the operand-A and operand-B serial-in shift registers and enables their parallel outputs. It then starts the adder, captures the 16-bit sum and returns it LSB-first on a serial output. It sits between the external serial port and the two operand shift registers plus the adder core.

---
 rtl/fp_io_sequencer.sv | 159 +++++++++++++++
 tb/tb_fp_io_sequencer.sv | 203 ++++++++++++++++++++
 2 files changed

// File: rtl/fp_io_sequencer.sv
// Transaction controller for the half-precision adder serial I/O path:
// loads operands A and B bit-serially, runs the adder, and returns the sum LSB-first.
module fp_io_sequencer #(
    parameter int WIDTH   = 16,
    parameter int TIMEOUT = 64
) (
    input  logic             clk_in,
    input  logic             rst_n_in,
    input  logic             start_in,
    input  logic             abort_in,
    input  logic             serial_in,
    input  logic             bit_valid_in,
    output logic             wr_a_out,
    output logic             wr_b_out,
    output logic             op_en_out,
    output logic             add_start_out,
    input  logic             add_done_in,
    input  logic [WIDTH-1:0] result_in,
    output logic             serial_out,
    output logic             serial_valid_out,
    output logic             done_out,
    output logic             busy_out,
    output logic             err_out
);

    localparam int CW = $clog2(WIDTH);
    localparam int TW = $clog2(TIMEOUT);
    localparam logic [CW-1:0] BIT_LAST  = CW'(WIDTH - 1);
    localparam logic [TW-1:0] TIME_LAST = TW'(TIMEOUT - 1);

    typedef enum logic [2:0] {
        IDLE,
        LOAD_A,
        LOAD_B,
        ENABLE,
        START,
        WAIT,
        SHIFT_OUT
    } state_t;

    state_t           state, state_next;
    logic [CW-1:0]    bit_cnt, bit_cnt_next;
    logic [TW-1:0]    time_cnt, time_cnt_next;
    logic [WIDTH-1:0] result, result_next;
    logic             err_next;
    logic             done_next;

    // The operand data line feeds the operand shift registers directly; only its
    // qualifier is consumed here.
    logic unused_serial;
    assign unused_serial = serial_in;

    assign wr_a_out = (state == LOAD_A) && bit_valid_in;
    assign wr_b_out = (state == LOAD_B) && bit_valid_in;
    assign busy_out = (state != IDLE);

    always_comb begin
        // NOTE: every variable gets a default before the case so no path leaves it
        // unassigned, which would otherwise infer a latch.
        state_next    = state;
        bit_cnt_next  = bit_cnt;
        time_cnt_next = time_cnt;
        result_next   = result;
        err_next      = err_out;
        done_next     = 1'b0;

        case (state)
            IDLE: begin
                if (start_in) begin
                    state_next   = LOAD_A;
                    bit_cnt_next = '0;
                    err_next     = 1'b0;
                end
            end
            LOAD_A, LOAD_B: begin
                if (bit_valid_in) begin
                    if (bit_cnt == BIT_LAST) begin
                        state_next   = (state == LOAD_A) ? LOAD_B : ENABLE;
                        bit_cnt_next = '0;
                    end else begin
                        bit_cnt_next = bit_cnt + 1'b1;
                    end
                end
            end
            ENABLE: state_next = START;
            START: begin
                time_cnt_next = '0;
                state_next    = WAIT;
            end
            WAIT: begin
                // A done arriving on the final timeout cycle still wins.
                if (add_done_in) begin
                    result_next  = result_in;
                    bit_cnt_next = '0;
                    state_next   = SHIFT_OUT;
                end else if (time_cnt == TIME_LAST) begin
                    err_next      = 1'b1;
                    time_cnt_next = '0;
                    state_next    = IDLE;
                end else begin
                    time_cnt_next = time_cnt + 1'b1;
                end
            end
            SHIFT_OUT: begin
                result_next = result >> 1;
                if (bit_cnt == BIT_LAST) begin
                    bit_cnt_next = '0;
                    done_next    = 1'b1;
                    state_next   = IDLE;
                end else begin
                    bit_cnt_next = bit_cnt + 1'b1;
                end
            end
            default: state_next = IDLE;
        endcase

        // Abort overrides everything but leaves the sticky error untouched.
        if (abort_in) begin
            state_next    = IDLE;
            bit_cnt_next  = '0;
            time_cnt_next = '0;
            result_next   = '0;
            done_next     = 1'b0;
            err_next      = err_out;
        end
    end

    // Registered outputs are computed from the next state so they line up with
    // the state they describe rather than trailing it by a cycle.
    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            state            <= IDLE;
            bit_cnt          <= '0;
            time_cnt         <= '0;
            // NOTE: the result register is reset too so a restarted transaction can
            // never shift out a stale sum.
            result           <= '0;
            op_en_out        <= 1'b0;
            add_start_out    <= 1'b0;
            serial_out       <= 1'b0;
            serial_valid_out <= 1'b0;
            done_out         <= 1'b0;
            err_out          <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments so every flop samples pre-edge values.
            state            <= state_next;
            bit_cnt          <= bit_cnt_next;
            time_cnt         <= time_cnt_next;
            result           <= result_next;
            op_en_out        <= (state_next inside {ENABLE, START, WAIT});
            add_start_out    <= (state_next == START);
            serial_out       <= (state_next == SHIFT_OUT) && result_next[0];
            serial_valid_out <= (state_next == SHIFT_OUT);
            done_out         <= done_next;
            err_out          <= err_next;
        end
    end

endmodule

// File: tb/tb_fp_io_sequencer.sv
// Directed bench for fp_io_sequencer: a bench-side adder model answers add_start_out,
// and the expected sums queued while operands are streamed are checked against the serial output.
module tb_fp_io_sequencer;

    localparam int WIDTH = 16;

    logic             clk_in = 1'b0;
    logic             rst_n_in;
    logic             start_in, abort_in, serial_in, bit_valid_in;
    logic             wr_a_out, wr_b_out, op_en_out, add_start_out;
    logic             add_done_in;
    logic [WIDTH-1:0] result_in;
    logic             serial_out, serial_valid_out, done_out, busy_out, err_out;

    fp_io_sequencer #(.WIDTH(WIDTH), .TIMEOUT(64)) dut (
        .clk_in           (clk_in),
        .rst_n_in         (rst_n_in),
        .start_in         (start_in),
        .abort_in         (abort_in),
        .serial_in        (serial_in),
        .bit_valid_in     (bit_valid_in),
        .wr_a_out         (wr_a_out),
        .wr_b_out         (wr_b_out),
        .op_en_out        (op_en_out),
        .add_start_out    (add_start_out),
        .add_done_in      (add_done_in),
        .result_in        (result_in),
        .serial_out       (serial_out),
        .serial_valid_out (serial_valid_out),
        .done_out         (done_out),
        .busy_out         (busy_out),
        .err_out          (err_out)
    );

    always #5 clk_in = ~clk_in;

    int checks = 0;
    int errors = 0;

    int               cyc = 0;
    int               n_wa, n_wb, n_ser, n_done;
    int               start_cyc, done_cyc, err_rise, done_at;
    logic             err_d = 1'b0;
    logic [WIDTH-1:0] cap_a, cap_b, ser_acc;
    logic             model_on;
    int               model_dly;
    logic [WIDTH-1:0] model_sum;
    logic [WIDTH-1:0] exp_q[$];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic clear_counters();
        n_wa = 0; n_wb = 0; n_ser = 0; n_done = 0;
        start_cyc = -1; done_cyc = -1; err_rise = -1; done_at = -1;
        cap_a = '0; cap_b = '0; ser_acc = '0;
    endtask

    // One clock cycle: drive inputs just after the rising edge, sample at the falling edge.
    task automatic step(input logic st, input logic ab, input logic bv, input logic si);
        @(posedge clk_in);
        #1;
        cyc++;
        start_in     = st;
        abort_in     = ab;
        bit_valid_in = bv;
        serial_in    = si;
        add_done_in  = (cyc == done_at);
        result_in    = (cyc == done_at) ? model_sum : 16'($urandom);
        @(negedge clk_in);
        if (wr_a_out) begin n_wa++; cap_a = {serial_in, cap_a[WIDTH-1:1]}; end
        if (wr_b_out) begin n_wb++; cap_b = {serial_in, cap_b[WIDTH-1:1]}; end
        if (add_start_out) begin
            start_cyc = cyc;
            if (model_on) done_at = cyc + model_dly;
        end
        if (serial_valid_out) begin n_ser++; ser_acc = {serial_out, ser_acc[WIDTH-1:1]}; end
        if (done_out) begin
            n_done++;
            done_cyc = cyc;
            check("scoreboard_nonempty", 32'(exp_q.size() > 0), 1);
            if (exp_q.size() > 0) check("serial_result", 32'(ser_acc), 32'(exp_q.pop_front()));
        end
        if (err_out && !err_d) err_rise = cyc;
        err_d = err_out;
    endtask

    task automatic run_txn(input string name, input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                           input logic [WIDTH-1:0] sum, input bit gap, input int dly, input bit on);
        int c0;
        logic bitv;
        clear_counters();
        model_on  = on;
        model_dly = dly;
        model_sum = sum;
        c0 = cyc + 1;
        step(1'b1, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 2 * WIDTH; i++) begin
            bitv = (i < WIDTH) ? a[i] : b[i - WIDTH];
            if (gap) step(1'b0, 1'b0, 1'b0, 1'b0);
            // start_in is held high while loading to show it is ignored outside IDLE
            step(1'b1, 1'b0, 1'b1, bitv);
        end
        if (on) exp_q.push_back(sum);
        for (int t = 0; t < 300 && n_done == 0 && err_rise < 0; t++)
            step(1'b0, 1'b0, 1'b1, 1'b0);
        check({name, "_wr_a_count"}, 32'(n_wa), WIDTH);
        check({name, "_wr_b_count"}, 32'(n_wb), WIDTH);
        check({name, "_operand_a"}, 32'(cap_a), 32'(a));
        check({name, "_operand_b"}, 32'(cap_b), 32'(b));
        check({name, "_add_start_cycle"}, 32'(start_cyc), 32'(c0 + (gap ? 66 : 34)));
        check({name, "_busy_after"}, 32'(busy_out), 0);
        if (on) begin
            check({name, "_done_count"}, 32'(n_done), 1);
            check({name, "_done_cycle"}, 32'(done_cyc), 32'(start_cyc + dly + WIDTH + 1));
            check({name, "_serial_bits"}, 32'(n_ser), WIDTH);
            check({name, "_err_clear"}, 32'(err_out), 0);
        end else begin
            check({name, "_err_rise_cycle"}, 32'(err_rise), 32'(start_cyc + 65));
            check({name, "_no_serial"}, 32'(n_ser), 0);
            check({name, "_no_done"}, 32'(n_done), 0);
        end
    endtask

    initial begin
        rst_n_in = 1'b0;
        start_in = 1'b0; abort_in = 1'b0; serial_in = 1'b0; bit_valid_in = 1'b0;
        add_done_in = 1'b0; result_in = '0;
        model_on = 1'b0; model_dly = 0; model_sum = '0;
        clear_counters();
        repeat (3) @(posedge clk_in);
        #2;
        check("reset_outputs", {wr_a_out, wr_b_out, op_en_out, add_start_out, serial_out,
                                serial_valid_out, done_out, busy_out, err_out}, 0);
        rst_n_in = 1'b1;
        step(1'b0, 1'b0, 1'b0, 1'b0);

        // 1.0 + 2.0 = 3.0, adder answers three cycles after its start pulse
        run_txn("full", 16'h3C00, 16'h4000, 16'h4200, 1'b0, 3, 1'b1);

        // 4.0 + 0.5 = 4.5, gapped input, minimum WAIT-to-serial latency
        run_txn("gapped", 16'h4400, 16'h3800, 16'h4480, 1'b1, 1, 1'b1);

        // Adder never answers
        run_txn("timeout", 16'h1234, 16'hABCD, 16'h0000, 1'b0, 0, 1'b0);

        // start together with abort in IDLE: stays idle, sticky error kept
        step(1'b1, 1'b1, 1'b0, 1'b0);
        step(1'b0, 1'b0, 1'b0, 1'b0);
        check("start_abort_idle", 32'(busy_out), 0);
        check("abort_keeps_err", 32'(err_out), 1);

        // Done on the final timeout cycle beats the timeout: 1.0 + 1.0 = 2.0
        run_txn("collision", 16'h3C00, 16'h3C00, 16'h4000, 1'b0, 64, 1'b1);

        // Abort at bit 9 of operand B
        clear_counters();
        model_on = 1'b0;
        step(1'b1, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < WIDTH + 9; i++) step(1'b0, 1'b0, 1'b1, 1'b1);
        step(1'b0, 1'b1, 1'b1, 1'b1);
        step(1'b0, 1'b0, 1'b0, 1'b0);
        check("abort_busy", {31'd0, busy_out}, 0);
        check("abort_op_en", {31'd0, op_en_out}, 0);
        for (int i = 0; i < 40; i++) step(1'b0, 1'b0, 1'b1, 1'b0);
        check("abort_wr_b_count", 32'(n_wb), 10);
        check("abort_no_start", 32'(start_cyc), 32'(-1));
        check("abort_no_done", 32'(n_done), 0);
        // 5.0 + -1.0 = 4.0
        run_txn("post_abort", 16'h4500, 16'hBC00, 16'h4400, 1'b0, 2, 1'b1);

        // Reset asserted mid-LOAD_B with bit_valid_in still high
        clear_counters();
        step(1'b1, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < WIDTH + 5; i++) step(1'b0, 1'b0, 1'b1, 1'b0);
        @(posedge clk_in);
        #3;
        rst_n_in = 1'b0;
        #1;
        check("midload_reset_outputs", {wr_a_out, wr_b_out, op_en_out, add_start_out, serial_out,
                                        serial_valid_out, done_out, busy_out, err_out}, 0);
        @(posedge clk_in);
        #3;
        rst_n_in = 1'b1;
        clear_counters();
        for (int i = 0; i < 10; i++) step(1'b0, 1'b0, 1'b1, 1'b1);
        check("post_reset_no_writes", 32'(n_wa + n_wb), 0);
        check("post_reset_idle", 32'(busy_out), 0);
        // 2.0 + 2.0 = 4.0
        run_txn("post_reset", 16'h4000, 16'h4000, 16'h4400, 1'b0, 5, 1'b1);

        check("scoreboard_drained", 32'(exp_q.size()), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
